// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: one outstanding fetch, a circular buffer of {word, pc}, and redirect flush.
// Optional macro PFQ_SPEC_BRANCH_EN: follow a direct-branch encoding (word[31:25]=7'b1100000) when choosing the next fetch address.
module prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic [31:0]              prefetch,
    output logic [31:0]              prefetch_pc,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_q, fetch_d;
    logic [31:0]     drop_addr_q, drop_addr_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];
    logic            wr, pop;
    logic [31:0]     next_fetch;

    // In REQ the request address is fetch_q itself; in DROP the abandoned address is held separately.
    always_comb begin
        next_fetch = fetch_q + 32'd4;
`ifdef PFQ_SPEC_BRANCH_EN
        if (mem_rdata[31:25] == 7'b1100000) begin
            next_fetch = fetch_q + {{16{mem_rdata[15]}}, mem_rdata[15:0]};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        drop_addr_d = drop_addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        wr          = 1'b0;
        pop         = 1'b0;
        if (redirect) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            fetch_d = redirect_pc;
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    state_d     = mem_ack ? REQ : DROP;
                    drop_addr_d = fetch_q;
                end
                DROP:    state_d = mem_ack ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            pop = deq && (count_q != '0);
            wr  = (state_q == REQ) && mem_ack;
            if (wr)  tail_d = tail_q + 1'b1;
            if (pop) head_d = head_q + 1'b1;
            count_d = count_q + CW'(wr) - CW'(pop);
            unique case (state_q)
                IDLE: if (count_q < DEPTH_C) state_d = REQ;
                REQ: begin
                    if (mem_ack) begin
                        fetch_d = next_fetch;
                        if (count_d == DEPTH_C) state_d = IDLE;
                    end
                end
                DROP:    if (mem_ack) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_q     <= RESET_PC;
            drop_addr_q <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            drop_addr_q <= drop_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            data_q[tail_q] <= mem_rdata;
            pc_q[tail_q]   <= fetch_q;
        end
    end

    assign mem_req     = (state_q != IDLE);
    assign mem_addr    = (state_q == DROP) ? drop_addr_q : fetch_q;
    assign valid       = (count_q != '0);
    assign count       = count_q;
    assign prefetch    = valid ? data_q[head_q] : '0;
    assign prefetch_pc = valid ? pc_q[head_q] : '0;

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  32  word address of the current request.
REQ-007 mem_ack  input  1  memory returns mem_rdata this cycle; ignored unless mem_req=1.
REQ-008 mem_rdata  input  32  returned instruction word.
REQ-009 redirect  input  1  flush the queue and restart fetching at redirect_pc.
REQ-010 redirect_pc  input  32  restart address, must be word-aligned.
REQ-011 deq  input  1  consumer takes the head entry this cycle.
REQ-012 prefetch  output  32  head instruction word; 0 when empty.
REQ-013 prefetch_pc  output  32  address of the head word; 0 when empty.
REQ-014 valid  output  1  head entry present.
REQ-015 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 The FSM SHALL have three states: IDLE (no request), REQ (request outstanding), DROP (outstanding request whose data is discarded).
REQ-017 At most one request SHALL be outstanding; IDLE moves to REQ when count plus the outstanding request is less than DEPTH and redirect=0.
REQ-018 In REQ, mem_req=1 and mem_addr SHALL stay stable until the cycle mem_ack=1.
REQ-019 On mem_ack in REQ without redirect:
  - write {mem_rdata, mem_addr} to the tail;
  - set fetch_addr = mem_addr+4, wrapping modulo 2^32;
  - stay in REQ if space remains after the write, otherwise go to IDLE.
REQ-020 Data reaches prefetch no earlier than the cycle after mem_ack (1-cycle write latency).
REQ-021 deq with valid=1 SHALL pop the head; deq with valid=0 SHALL be ignored, with no underflow.
REQ-022 Simultaneous write and pop SHALL leave count unchanged; the queue never overflows because requests are gated by free space.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 On redirect, the following SHALL take effect in the next cycle, and redirect has priority over deq and mem_ack:
  - count=0 and pointers cleared;
  - fetch_addr=redirect_pc;
  - any same-cycle ack data discarded.
REQ-025 Redirect while in REQ without mem_ack SHALL go to DROP; DROP keeps mem_req/mem_addr stable, discards the ack data, then goes to REQ at fetch_addr.
REQ-026 Redirect in DROP SHALL update fetch_addr and remain in DROP.
REQ-027 Redirect in IDLE, or with mem_ack in REQ, SHALL go to REQ at redirect_pc in the next cycle.

Reset
REQ-028 When reset=1, the following SHALL hold in the next cycle:
  - FSM in IDLE;
  - count=0, valid=0, mem_req=0;
  - prefetch=0, prefetch_pc=0, mem_addr=RESET_PC;
  - fetch_addr=RESET_PC.
REQ-029 Reset SHALL override redirect, deq and mem_ack. Reset during REQ SHALL abandon the request, and a late ack SHALL be ignored because mem_req=0.
REQ-030 After reset deasserts, the first request SHALL be issued in the following cycle at RESET_PC.

Configuration
REQ-031 With PFQ_SPEC_BRANCH_EN defined, a written word with [31:25]=7'b1100000 SHALL set fetch_addr to mem_addr plus sign-extended [15:0] instead of mem_addr+4.
REQ-032 Without PFQ_SPEC_BRANCH_EN defined, fetch_addr SHALL always advance by 4 (REQ-019); the queue stores the word either way.

Verification
REQ-033 Reset, then memory acks every cycle with no deq:
  - addresses 0,4,8,12;
  - count reaches 4, mem_req=0.
REQ-034 Full queue, deq=1 for one cycle:
  - count=3, next request issued at 16;
  - prefetch_pc steps 0 to 4.
REQ-035 Redirect to 0x100 in a cycle with no ack during REQ:
  - DROP, ack data not written, count=0;
  - next request at 0x100.
REQ-036 Redirect and mem_ack in the same cycle:
  - data discarded;
  - next mem_addr=redirect_pc;
  - deq in that cycle has no effect.
REQ-037 deq while empty: count stays 0, prefetch=0.
REQ-038 With PFQ_SPEC_BRANCH_EN, word 0xC000FFF8 acked at 0x20: next mem_addr=0x18. Without the macro: next mem_addr=0x24.
